// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master round-robin arbiter in front of a single-port synchronous RAM.
//   clk, rst_n (async active-low)
//   a_req/a_we/a_addr/a_wdata -> a_gnt, a_rvalid, a_rdata  (master A)
//   b_req/b_we/b_addr/b_wdata -> b_gnt, b_rvalid, b_rdata  (master B)
//   ram_we/ram_addr/ram_din -> RAM, ram_dout <- RAM (1-cycle read latency)
//   RAM_ARB_STATS_EN: adds stats_clr input and saturating a_gnt_cnt/b_gnt_cnt outputs
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
`ifdef RAM_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       a_gnt_cnt,
  output logic [15:0]       b_gnt_cnt,
`endif
  input  logic [DATA_W-1:0] ram_dout
);
  // prio = 0 favours A, 1 favours B under contention
  logic prio;
  assign a_gnt    = a_req & (~b_req | ~prio);
  assign b_gnt    = b_req & (~a_req | prio);
  assign ram_we   = a_gnt ? a_we : (b_gnt & b_we);
  assign ram_addr = a_gnt ? a_addr : b_gnt ? b_addr : '0;
  assign ram_din  = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
  // read data is only meaningful while the matching rvalid is high
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;
  // the rvalid flops double as the read-owner record for the returning RAM word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prio     <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      prio     <= a_gnt ? 1'b1 : b_gnt ? 1'b0 : prio;
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
    end
`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_gnt_cnt <= '0;
      b_gnt_cnt <= '0;
    end else if (stats_clr) begin
      a_gnt_cnt <= '0;
      b_gnt_cnt <= '0;
    end else begin
      a_gnt_cnt <= (a_gnt && a_gnt_cnt != 16'hFFFF) ? a_gnt_cnt + 16'd1 : a_gnt_cnt;
      b_gnt_cnt <= (b_gnt && b_gnt_cnt != 16'hFFFF) ? b_gnt_cnt + 16'd1 : b_gnt_cnt;
    end
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scoreboard bench for ram_arbiter with a behavioural RAM.
module tb_ram_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we;
  logic [7:0] a_rdata, b_rdata, ram_din, ram_dout;
  logic [3:0] ram_addr;
  logic       stats_clr = 1'b0;
  logic [15:0] a_gnt_cnt, b_gnt_cnt;
  logic [7:0] mem [16];
  logic [7:0] shadow [16];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic       pa = 1'b0, pb = 1'b0;
  int         ca = 0, cb = 0;
  int         errors = 0, checks = 0;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
`ifdef RAM_ARB_STATS_EN
    .stats_clr(stats_clr), .a_gnt_cnt(a_gnt_cnt), .b_gnt_cnt(b_gnt_cnt),
`endif
    .ram_dout(ram_dout)
  );
`ifndef RAM_ARB_STATS_EN
  assign a_gnt_cnt = '0;
  assign b_gnt_cnt = '0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ar, input logic aw, input logic [3:0] aa, input logic [7:0] ad,
                      input logic br, input logic bw, input logic [3:0] ba, input logic [7:0] bd,
                      input logic ega, input logic egb, input logic clr = 1'b0);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    stats_clr = clr;
    @(negedge clk);
    chk("a_gnt", 16'(a_gnt), 16'(ega));
    chk("b_gnt", 16'(b_gnt), 16'(egb));
    chk("ram_we", 16'(ram_we), 16'(ega ? aw : egb & bw));
    chk("ram_addr", 16'(ram_addr), 16'(ega ? aa : egb ? ba : 4'd0));
    chk("ram_din", 16'(ram_din), 16'(ega ? ad : egb ? bd : 8'd0));
    chk("a_rvalid", 16'(a_rvalid), 16'(pa));
    chk("b_rvalid", 16'(b_rvalid), 16'(pb));
    if (pa) chk("a_rdata", 16'(a_rdata), 16'(qa.pop_front()));
    if (pb) chk("b_rdata", 16'(b_rdata), 16'(qb.pop_front()));
    pa = ega & ~aw;
    pb = egb & ~bw;
    if (pa) qa.push_back(shadow[aa]);
    if (pb) qb.push_back(shadow[ba]);
    if (ega && aw) shadow[aa] = ad;
    if (egb && bw) shadow[ba] = bd;
    if (clr) begin ca = 0; cb = 0; end
    else begin ca += int'(ega); cb += int'(egb); end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 4'd0, 8'd0, 0, 0, 4'd0, 8'd0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0; stats_clr = 1'b0;
    #2;
    chk("rst_a_rvalid", 16'(a_rvalid), 16'd0);
    chk("rst_b_rvalid", 16'(b_rvalid), 16'd0);
    chk("rst_ram_we", 16'(ram_we), 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pa = 1'b0; pb = 1'b0; qa.delete(); qb.delete(); ca = 0; cb = 0;
  endtask

  initial begin
    #3;
    chk("init_a_gnt", 16'(a_gnt), 16'd0);
    chk("init_b_gnt", 16'(b_gnt), 16'd0);
    chk("init_ram_addr", 16'(ram_addr), 16'd0);
    chk("init_ram_din", 16'(ram_din), 16'd0);
    do_reset();
    // single master traffic, also seeds addresses used later
    step(1, 1, 4'd4, 8'hA5, 0, 0, 4'd0, 8'h00, 1, 0);
    step(1, 1, 4'd1, 8'h5A, 0, 0, 4'd0, 8'h00, 1, 0);
    step(0, 0, 4'd0, 8'h00, 1, 1, 4'd2, 8'hC3, 0, 1);
    step(1, 0, 4'd4, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    idle();
    // contention right after reset: A first
    do_reset();
    step(1, 0, 4'd4, 8'h00, 1, 0, 4'd4, 8'h00, 1, 0);
    step(0, 0, 4'd0, 8'h00, 1, 0, 4'd4, 8'h00, 0, 1);
    idle();
    // continuous contention alternates starting with A
    for (int i = 0; i < 6; i++)
      step(1, 0, 4'd1, 8'h00, 1, 0, 4'd2, 8'h00, (i % 2) == 0, (i % 2) == 1);
    idle();
    // ordering hazard: pointer at B, B write wins over A read of same address
    step(1, 1, 4'd7, 8'h11, 0, 0, 4'd0, 8'h00, 1, 0);
    step(1, 0, 4'd7, 8'h00, 1, 1, 4'd7, 8'h3C, 0, 1);
    step(1, 0, 4'd7, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    idle();
    // async reset between a read grant and its return
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd7; b_req = 1'b0;
    @(negedge clk);
    chk("mid_a_gnt", 16'(a_gnt), 16'd1);
    rst_n = 1'b0;
    a_req = 1'b0;
    #1;
    chk("mid_a_gnt_off", 16'(a_gnt), 16'd0);
    chk("mid_ram_addr", 16'(ram_addr), 16'd0);
    @(posedge clk); #1;
    chk("mid_a_rvalid", 16'(a_rvalid), 16'd0);
    @(posedge clk); #1;
    chk("mid_a_rvalid2", 16'(a_rvalid), 16'd0);
    rst_n = 1'b1;
    pa = 1'b0; pb = 1'b0; qa.delete(); qb.delete(); ca = 0; cb = 0;
    idle();
    step(1, 0, 4'd7, 8'h00, 1, 0, 4'd7, 8'h00, 1, 0);
    idle();
`ifdef RAM_ARB_STATS_EN
    step(1, 0, 4'd1, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0, 1'b1);
    chk("cnt_clr_a", a_gnt_cnt, 16'(ca));
    chk("cnt_clr_b", b_gnt_cnt, 16'(cb));
    for (int i = 0; i < 5; i++) step(1, 1, 4'(8 + i), 8'(i), 0, 0, 4'd0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 4'd0, 8'h00, 1, 1, 4'(12 + i), 8'(i), 0, 1);
    chk("cnt_a5", a_gnt_cnt, 16'd5);
    chk("cnt_b3", b_gnt_cnt, 16'd3);
    step(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0, 1'b1);
    chk("cnt_a0", a_gnt_cnt, 16'd0);
    chk("cnt_b0", b_gnt_cnt, 16'd0);
`endif
    chk("qa_empty", 16'(qa.size()), 16'd0);
    chk("qb_empty", 16'(qb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester round-robin arbiter that shares the single-port synchronous RAM (clk, we, addr, din, dout) between two masters, A and B. Each master issues read/write commands over a req/gnt handshake. The arbiter drives the RAM port and returns read data with a registered valid strobe. It sits directly in front of the RAM instance; the masters never touch the RAM port directly.

Parameters:
ADDR_W, 4, RAM address width (16 words)
DATA_W, 8, RAM data width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
a_req  input  1  master A command valid
a_we  input  1  master A command is write (1) / read (0)
a_addr  input  ADDR_W  master A address
a_wdata  input  DATA_W  master A write data
a_gnt  output  1  master A command accepted this cycle
a_rvalid  output  1  master A read data valid
a_rdata  output  DATA_W  master A read data
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for master B
ram_we  output  1  to RAM we
ram_addr  output  ADDR_W  to RAM addr
ram_din  output  DATA_W  to RAM din
ram_dout  input  DATA_W  from RAM dout; valid the cycle after a read address is presented

Behaviour:
- Reset (rst_n low, async): prio pointer = A; a_rvalid = b_rvalid = 0; internal rd_owner cleared.
- Combinational outputs a_gnt, b_gnt, ram_we, ram_addr and ram_din are 0 whenever no req is asserted, including during reset.
- Handshake: master holds req, we, addr and wdata stable until it samples gnt = 1 on a rising edge. Command is transferred on that edge. Master may re-assert req the next cycle. Deasserting req before gnt is permitted; the command is dropped.
- Grant is combinational, at most one per cycle:
  - only A requests -> a_gnt = 1
  - only B requests -> b_gnt = 1
  - both request -> master at prio pointer wins
- Pointer update on any grant: pointer <= the non-granted master. No grant -> pointer holds. Result: strict alternation under continuous contention.
- RAM drive (combinational from winner): ram_addr = winner addr; ram_din = winner wdata; ram_we = gnt & winner we. No winner -> ram_we = 0, ram_addr = 0, ram_din = 0.
- Read return:
  - Granted read in cycle N -> x_rvalid = 1 in cycle N+1 for exactly one cycle; x_rdata = ram_dout in that cycle.
  - x_rdata passes ram_dout through combinationally. Its value is defined only while x_rvalid is high.
- Write: takes effect at the grant edge; no response strobe. A read of the same address granted the next cycle returns the new data.
- Back-to-back: a master may be granted every cycle (if uncontended). Reads are fully pipelined, 1 cycle latency, no bubbles.
- Simultaneous A write and B read to the same address: the grant order decides. The loser's command is served later and sees post-write state.
- Reset mid-operation: any in-flight read's rvalid is suppressed; the pending command is lost; the pointer returns to A.
- Width rules: addresses wrap naturally at 2^ADDR_W; no range check.

Optional Feature:
Macro RAM_ARB_STATS_EN.
- Defined: adds outputs a_gnt_cnt[15:0] and b_gnt_cnt[15:0], plus input stats_clr.
  - Each counter increments on its master's grant and saturates at 16'hFFFF.
  - Counters reset to 0 on rst_n low.
  - stats_clr = 1 zeroes both counters synchronously. A grant in the same cycle as stats_clr is not counted.
- Not defined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single writer/reader: A writes 8'hA5 @4, then A reads @4 -> a_gnt each cycle; a_rvalid = 1 one cycle after the read grant with a_rdata = 8'hA5; b_rvalid stays 0.
- Contention after reset: A and B both read @4 in the same cycle -> A granted first (pointer = A), B granted the next cycle; rvalid strobes arrive on consecutive cycles with data 8'hA5.
- Continuous contention: A and B hold req for 6 cycles -> grants alternate A,B,A,B,A,B; no cycle has both or neither gnt.
- Ordering hazard: B writes 8'h3C @7 and A reads @7 requested together with pointer = B -> B granted first; A's read returns 8'h3C.
- Async reset mid-read: assert rst_n low between an A read grant and its return -> a_rvalid never pulses; after release, pointer = A and outputs idle.
- With RAM_ARB_STATS_EN: 5 A grants and 3 B grants -> a_gnt_cnt = 5, b_gnt_cnt = 3. Pulse stats_clr -> both 0.
